lfsr_checker: RTL
=================

Name: lfsr_checker

Overview:
- Receive-side companion to the synth's 31-bit pseudo-random noise generator (XNOR feedback, taps 31 and 28, one shift per enable, 16-bit window of register bits 16:1).
- Takes the 16-bit sample stream from the generator and self-synchronises a local 31-bit shadow register to it.
- Once locked, predicts every following sample and counts mismatches.
- Used in bring-up and BIST to check the noise path end to end.

Parameters:
- NUM_BITS, 31: shadow register length. Feedback taps are fixed at NUM_BITS and NUM_BITS-3; only 31 is supported.
- ERR_LIMIT, 4: number of consecutive mismatched samples in LOCKED that drops lock. Legal range 1..15.
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset. Asserts immediately; deasserts synchronously with clk.
- clear  input  1  synchronous clear of err_count and the sticky flag. FSM state is untouched.
- sample_valid  input  1  qualifies sample_data for one cycle. Exactly one generator shift per valid.
- sample_data  input  16  generator output word, where bit 0 is the newest bit.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse for each mismatched sample while LOCKED.
- lock_lost  output  1  one-cycle pulse on the LOCKED->ACQUIRE transition.
- err_sticky  output  1  set by any err_pulse, cleared only by clear or reset.
- err_count  output  CNT_W  count of mismatched samples while LOCKED. Saturates at all-ones.

Behaviour:
- Reset values: all outputs 0, shadow 0, acq_cnt 0, run_cnt 0, state IDLE.
- Outputs are registered and reflect a valid sample one clk after that sample's cycle. With sample_valid low, all state holds and pulses are 0.
- IDLE, first valid sample:
  - load shadow[16:1] from sample_data; acq_cnt=16; go to ACQUIRE.
- ACQUIRE, each valid sample:
  - Continuity check: sample_data[15:1] must equal shadow[15:1].
  - Pass: shadow <= {shadow[30:1], sample_data[0]}; acq_cnt++.
  - Fail: reload shadow[16:1] from sample_data, keep the other shadow bits, acq_cnt=16.
  - When acq_cnt reaches 31 on a passing sample: if the new shadow is all ones (the XNOR lockup state), reload as for a fail; otherwise go to LOCKED.
  - Result: a clean stream locks on the 16th valid sample; locked is high the following cycle.
- LOCKED, each valid sample:
  - pred = shadow[31] XNOR shadow[28]; expected = {shadow[15:1], pred}.
  - The shadow always advances with pred (flywheel), never with received data.
  - Match: run_cnt=0.
  - Mismatch: err_pulse=1, err_sticky=1, err_count++ (saturating), run_cnt++.
  - When run_cnt reaches ERR_LIMIT: lock_lost=1, locked=0, state ACQUIRE.
  - On that transition, reload shadow[16:1] from the current sample, acq_cnt=16, run_cnt=0.
- Simultaneous clear and mismatch: the clear wins, so err_count=0 and err_sticky=0 for that cycle. The FSM and run_cnt still update.
- Saturation: at all-ones, err_count holds while err_pulse still fires.
- Reset mid-operation forces the reset values regardless of state.
- Generator reset restarting at 0x0000 while LOCKED: treated as mismatches, then lock_lost after ERR_LIMIT samples, then reacquire.

Test Plan:
- Generator (reset to 0) feeds the checker with valid every cycle, words 0x0000, 0x0001, 0x0003, ... -> locked rises 1 cycle after the 16th valid. Next 10000 samples: err_count=0, err_sticky=0.
- After lock, sample 100 has bit 0 inverted -> err_pulse exactly once, err_count=1, err_sticky=1, locked stays 1. The following clean samples produce no errors (flywheel).
- After lock, 4 consecutive samples with bit 0 inverted -> err_count=4, lock_lost pulses once after the 4th, locked=0. Relock 16 valid samples later. 3 consecutive bad samples followed by 1 good must not drop lock.
- During ACQUIRE, feed 0x1234 at sample 8 (continuity break) -> acq_cnt restarts and lock comes 16 valids after the break, not before. A stream of 0xFFFF words never locks.
- ERR_LIMIT=15 with 0xFFFF errors: err_count saturates and holds. Asserting clear together with a mismatch -> err_count=0, err_sticky=0.
- Gaps of 0-5 idle cycles between valid samples -> lock timing counted in valids only, zero errors. reset_n low for 1 cycle while LOCKED -> all outputs 0 immediately, then normal relock.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 31-bit XNOR noise generator (taps 31/28, 16-bit window of bits 16:1).
// Self-synchronises a shadow register to the sample stream, then flywheels it and counts mismatches.
module lfsr_checker #(
    parameter int NUM_BITS  = 31,
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [15:0]      sample_data,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS:1]   shadow_q, shadow_d;
    logic [4:0]          acq_cnt_q, acq_cnt_d;
    logic [3:0]          run_cnt_q, run_cnt_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic                lock_lost_q, lock_lost_d;
    logic                err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;

    logic                pred;
    logic [15:0]         expected;
    logic [NUM_BITS:1]   shadow_shift_rx;
    logic [NUM_BITS:1]   shadow_reload;

    always_comb begin
        pred            = shadow_q[NUM_BITS] ~^ shadow_q[NUM_BITS-3];
        expected        = {shadow_q[15:1], pred};
        shadow_shift_rx = {shadow_q[NUM_BITS-1:1], sample_data[0]};
        // Reload replaces only the window bits; the older history bits are kept.
        shadow_reload   = {shadow_q[NUM_BITS:17], sample_data};

        state_d      = state_q;
        shadow_d     = shadow_q;
        acq_cnt_d    = acq_cnt_q;
        run_cnt_d    = run_cnt_q;
        err_pulse_d  = 1'b0;
        lock_lost_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (sample_valid) begin
            case (state_q)
                ST_IDLE: begin
                    shadow_d  = shadow_reload;
                    acq_cnt_d = 5'd16;
                    state_d   = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (sample_data[15:1] == shadow_q[15:1]) begin
                        if (acq_cnt_q == 5'd30) begin
                            // All ones is the XNOR lockup state: never lock onto it.
                            if (&shadow_shift_rx) begin
                                shadow_d  = shadow_reload;
                                acq_cnt_d = 5'd16;
                            end else begin
                                shadow_d  = shadow_shift_rx;
                                acq_cnt_d = 5'd31;
                                run_cnt_d = 4'd0;
                                state_d   = ST_LOCKED;
                            end
                        end else begin
                            shadow_d  = shadow_shift_rx;
                            acq_cnt_d = acq_cnt_q + 5'd1;
                        end
                    end else begin
                        shadow_d  = shadow_reload;
                        acq_cnt_d = 5'd16;
                    end
                end
                ST_LOCKED: begin
                    shadow_d = {shadow_q[NUM_BITS-1:1], pred};
                    if (sample_data != expected) begin
                        err_pulse_d  = 1'b1;
                        err_sticky_d = 1'b1;
                        if (err_count_q != {CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (run_cnt_q == 4'(ERR_LIMIT - 1)) begin
                            lock_lost_d = 1'b1;
                            shadow_d    = shadow_reload;
                            acq_cnt_d   = 5'd16;
                            run_cnt_d   = 4'd0;
                            state_d     = ST_ACQUIRE;
                        end else begin
                            run_cnt_d = run_cnt_q + 4'd1;
                        end
                    end else begin
                        run_cnt_d = 4'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clear) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            acq_cnt_q    <= '0;
            run_cnt_q    <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            lock_lost_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            acq_cnt_q    <= acq_cnt_d;
            run_cnt_q    <= run_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            lock_lost_q  <= lock_lost_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign lock_lost  = lock_lost_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign dbg_state  = state_q;

endmodule
